// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO responder slice.
package mmio_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [15:0] BASE_HI_DEFAULT = 16'h1FAF;

   localparam logic [15:0] OFF_SCRATCH0 = 16'h0000;
   localparam logic [15:0] OFF_SCRATCH1 = 16'h0004;
   localparam logic [15:0] OFF_LED      = 16'h0008;
   localparam logic [15:0] OFF_COUNTER  = 16'h000C;
   localparam logic [15:0] OFF_CMP      = 16'h0010;
   localparam logic [15:0] OFF_STATUS   = 16'h0014;

   // Replace the bytes of old_val selected by strobe with those of new_val.
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strobe);
      logic [31:0] r;
      r = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strobe[b]) r[8*b +: 8] = new_val[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/mmio_if.sv
// Two-phase addr_ok/data_ok request/response bus between CPU side and MMIO block.
interface mmio_if;
   logic        req_valid;
   logic [31:0] req_addr;
   logic [3:0]  req_strobe;
   logic [31:0] req_data;
   logic        resp_addr_ok;
   logic        resp_data_ok;
   logic [31:0] resp_data;

   modport master (
      output req_valid, req_addr, req_strobe, req_data,
      input  resp_addr_ok, resp_data_ok, resp_data
   );

   modport slave (
      input  req_valid, req_addr, req_strobe, req_data,
      output resp_addr_ok, resp_data_ok, resp_data
   );
endinterface

// File: rtl/mmio_timer.sv
// Free-running counter with compare match flag. Only instantiated when
// MMIO_TIMER_EN is defined.
module mmio_timer
   import mmio_pkg::*;
(
   input  logic        clk,
   input  logic        resetn,
   input  logic        wr_cmp,
   input  logic        wr_status,
   input  logic [3:0]  wr_strobe,
   input  logic [31:0] wr_data,
   output logic [31:0] counter,
   output logic [31:0] cmp,
   output logic        match
);

   logic [31:0] counter_nxt;
   logic        match_set;
   logic        match_clr;

   assign counter_nxt = counter + 32'd1;
   assign match_set   = (counter_nxt == cmp);
   assign match_clr   = wr_status & wr_strobe[0] & wr_data[0];

   // Counter, compare register and sticky match flag; a set beats a clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         counter <= 32'd0;
         cmp     <= 32'd0;
         match   <= 1'b0;
      end else begin
         counter <= counter_nxt;
         if (wr_cmp) cmp <= byte_merge(cmp, wr_data, wr_strobe);
         match <= match_set | (match & ~match_clr);
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder for the physical register window BASE_HI:0000..FFFF.
// Define MMIO_TIMER_EN to include the counter/compare/status timer block.
//
// state | meaning
// IDLE  | addr_ok follows req_valid; accept captures read data, commits writes
// WAIT  | latency down-counter running
// RESP  | data_ok pulse with captured read data
module mmio_responder
   import mmio_pkg::*;
#(
   parameter int unsigned LATENCY = 1,
   parameter logic [15:0] BASE_HI = BASE_HI_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   mmio_if.slave       bus,
   output logic [15:0] led,
   output logic        irq
);

   localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

   state_t      state_q, state_d;
   logic [3:0]  wait_q, wait_d;
   logic        addr_ok, data_ok;
   logic        accept, is_write, hit, wr_en;
   logic [15:0] offset;
   logic [31:0] rdata_d, rdata_q;
   logic [31:0] scratch0_q, scratch1_q;
   logic [15:0] led_q;
   logic        unused_addr_bits;

   assign unused_addr_bits = &{1'b0, bus.req_addr[1:0]};

   assign hit      = (bus.req_addr[31:16] == BASE_HI);
   assign offset   = {bus.req_addr[15:2], 2'b00};
   assign is_write = |bus.req_strobe;
   assign accept   = addr_ok;
   assign wr_en    = accept & is_write & hit;

   // State and latency counter registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         wait_q  <= 4'd0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   // Next state and handshake outputs; addr_ok is held low while in reset.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      addr_ok = 1'b0;
      data_ok = 1'b0;
      case (state_q)
         IDLE: begin
            addr_ok = bus.req_valid & resetn;
            if (bus.req_valid) begin
               if (LATENCY == 1) begin
                  state_d = RESP;
               end else begin
                  state_d = WAIT;
                  wait_d  = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (wait_q == 4'd1) state_d = RESP;
            else                wait_d  = wait_q - 4'd1;
         end
         RESP: begin
            data_ok = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.resp_addr_ok = addr_ok;
   assign bus.resp_data_ok = data_ok;
   assign bus.resp_data    = data_ok ? rdata_q : 32'd0;

`ifdef MMIO_TIMER_EN
   logic [31:0] tmr_counter, tmr_cmp;
   logic        tmr_match;

   mmio_timer u_timer (
      .clk       (clk),
      .resetn    (resetn),
      .wr_cmp    (wr_en && offset == OFF_CMP),
      .wr_status (wr_en && offset == OFF_STATUS),
      .wr_strobe (bus.req_strobe),
      .wr_data   (bus.req_data),
      .counter   (tmr_counter),
      .cmp       (tmr_cmp),
      .match     (tmr_match)
   );

   assign irq = tmr_match;
`else
   assign irq = 1'b0;
`endif

   // Read decode; anything outside the window or map reads as zero.
   always_comb begin
      rdata_d = 32'd0;
      if (hit) begin
         case (offset)
            OFF_SCRATCH0: rdata_d = scratch0_q;
            OFF_SCRATCH1: rdata_d = scratch1_q;
            OFF_LED:      rdata_d = {16'd0, led_q};
`ifdef MMIO_TIMER_EN
            OFF_COUNTER:  rdata_d = tmr_counter;
            OFF_CMP:      rdata_d = tmr_cmp;
            OFF_STATUS:   rdata_d = {31'd0, tmr_match};
`endif
            default:      rdata_d = 32'd0;
         endcase
      end
   end

   // Register file writes and response capture at the accept edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scratch0_q <= 32'd0;
         scratch1_q <= 32'd0;
         led_q      <= 16'd0;
         rdata_q    <= 32'd0;
      end else begin
         if (accept) rdata_q <= rdata_d;
         if (wr_en && offset == OFF_SCRATCH0)
            scratch0_q <= byte_merge(scratch0_q, bus.req_data, bus.req_strobe);
         if (wr_en && offset == OFF_SCRATCH1)
            scratch1_q <= byte_merge(scratch1_q, bus.req_data, bus.req_strobe);
         if (wr_en && offset == OFF_LED) begin
            if (bus.req_strobe[0]) led_q[7:0]  <= bus.req_data[7:0];
            if (bus.req_strobe[1]) led_q[15:8] <= bus.req_data[15:8];
         end
      end
   end

   assign led = led_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: two instances (LATENCY 1 and 4) checked every
// cycle against a transaction-level model, plus literal expectations.
module tb_mmio_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn [2];
   logic        rv   [2];
   logic [31:0] ra   [2];
   logic [3:0]  rs   [2];
   logic [31:0] rd   [2];
   logic        aok  [2];
   logic        dok  [2];
   logic [31:0] dat  [2];
   logic [15:0] led  [2];
   logic        irq  [2];

   mmio_if ifa ();
   mmio_if ifb ();

   assign ifa.req_valid  = rv[0];
   assign ifa.req_addr   = ra[0];
   assign ifa.req_strobe = rs[0];
   assign ifa.req_data   = rd[0];
   assign aok[0] = ifa.resp_addr_ok;
   assign dok[0] = ifa.resp_data_ok;
   assign dat[0] = ifa.resp_data;

   assign ifb.req_valid  = rv[1];
   assign ifb.req_addr   = ra[1];
   assign ifb.req_strobe = rs[1];
   assign ifb.req_data   = rd[1];
   assign aok[1] = ifb.resp_addr_ok;
   assign dok[1] = ifb.resp_data_ok;
   assign dat[1] = ifb.resp_data;

   mmio_responder #(.LATENCY(1)) u_dut1 (
      .clk(clk), .resetn(rstn[0]), .bus(ifa), .led(led[0]), .irq(irq[0]));
   mmio_responder #(.LATENCY(4)) u_dut4 (
      .clk(clk), .resetn(rstn[1]), .bus(ifb), .led(led[1]), .irq(irq[1]));

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   int          lat    [2] = '{1, 4};
   int          m_left [2] = '{0, 0};   // cycles until the pending response shows
   logic [31:0] m_rdata[2];
   logic [31:0] m_scr0 [2];
   logic [31:0] m_scr1 [2];
   logic [15:0] m_led  [2];
   logic [31:0] m_cmp  [2];
   logic [31:0] m_cnt  [2];
   logic        m_match[2];

   function automatic logic [31:0] m_merge(input logic [31:0] o, input logic [31:0] n,
                                           input logic [3:0] s);
      logic [31:0] mask;
      mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      return (o & ~mask) | (n & mask);
   endfunction

   function automatic logic [31:0] m_read(input int i, input logic [31:0] a);
      logic [15:0] off;
      off = {a[15:2], 2'b00};
      if (a[31:16] != 16'h1FAF) return 32'h0;
      case (off)
         16'h0000: return m_scr0[i];
         16'h0004: return m_scr1[i];
         16'h0008: return {16'h0, m_led[i]};
`ifdef MMIO_TIMER_EN
         16'h000C: return m_cnt[i];
         16'h0010: return m_cmp[i];
         16'h0014: return {31'h0, m_match[i]};
`endif
         default:  return 32'h0;
      endcase
   endfunction

   task automatic model_step(input int i);
      logic        exp_aok, exp_dok, set, clr, exp_irq;
      logic [31:0] exp_dat;
      logic [15:0] off;
      if (rstn[i] !== 1'b1) begin
         m_left[i] = 0; m_rdata[i] = 0; m_scr0[i] = 0; m_scr1[i] = 0;
         m_led[i] = 0; m_cmp[i] = 0; m_cnt[i] = 0; m_match[i] = 0;
         chk($sformatf("u%0d.rst.aok", i), aok[i], 0);
         chk($sformatf("u%0d.rst.dok", i), dok[i], 0);
         chk($sformatf("u%0d.rst.data", i), dat[i], 0);
         chk($sformatf("u%0d.rst.led", i), led[i], 0);
         chk($sformatf("u%0d.rst.irq", i), irq[i], 0);
         return;
      end
      exp_aok = (m_left[i] == 0) && (rv[i] === 1'b1);
      exp_dok = (m_left[i] == 1);
      exp_dat = exp_dok ? m_rdata[i] : 32'h0;
`ifdef MMIO_TIMER_EN
      exp_irq = m_match[i];
`else
      exp_irq = 1'b0;
`endif
      chk($sformatf("u%0d.aok", i), aok[i], exp_aok);
      chk($sformatf("u%0d.dok", i), dok[i], exp_dok);
      chk($sformatf("u%0d.data", i), dat[i], exp_dat);
      chk($sformatf("u%0d.led", i), led[i], m_led[i]);
      chk($sformatf("u%0d.irq", i), irq[i], exp_irq);
      // advance to the next clock edge
      if (m_left[i] > 0) m_left[i]--;
      set = (m_cnt[i] + 32'd1 == m_cmp[i]);
      clr = 1'b0;
      if (exp_aok) begin
         m_rdata[i] = m_read(i, ra[i]);
         m_left[i]  = lat[i];
         off = {ra[i][15:2], 2'b00};
         if (rs[i] != 4'h0 && ra[i][31:16] == 16'h1FAF) begin
            case (off)
               16'h0000: m_scr0[i] = m_merge(m_scr0[i], rd[i], rs[i]);
               16'h0004: m_scr1[i] = m_merge(m_scr1[i], rd[i], rs[i]);
               16'h0008: m_led[i]  = m_merge({16'h0, m_led[i]}, rd[i], rs[i]) & 32'hFFFF;
`ifdef MMIO_TIMER_EN
               16'h0010: m_cmp[i]  = m_merge(m_cmp[i], rd[i], rs[i]);
               16'h0014: clr = rs[i][0] & rd[i][0];
`endif
               default: ;
            endcase
         end
      end
      m_match[i] = set | (m_match[i] & ~clr);
      m_cnt[i]   = m_cnt[i] + 32'd1;
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) model_step(i);
   end

   // ---------------- stimulus ----------------
   task automatic tout(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got timeout expected handshake (t=%0t)", nm, $time);
   endtask

   // Called at posedge+1; returns at posedge+1 after the response.
   task automatic do_req(input int i, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] q, output int l);
      int n;
      rv[i] = 1'b1; ra[i] = a; rs[i] = s; rd[i] = d;
      q = 32'h0; l = -1;
      n = 0;
      @(negedge clk);
      while (aok[i] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (aok[i] !== 1'b1) begin
         tout($sformatf("u%0d.addr_ok_wait", i));
         rv[i] = 1'b0;
         @(posedge clk); #1;
         return;
      end
      @(posedge clk); #1;
      rv[i] = 1'b0;
      n = 1;
      @(negedge clk);
      while (dok[i] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      if (dok[i] === 1'b1) begin
         q = dat[i];
         l = n;
      end else begin
         tout($sformatf("u%0d.data_ok_wait", i));
      end
      @(posedge clk); #1;
   endtask

   task automatic reset_pulse(input int i);
      rstn[i] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rstn[i] = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] q;
      int          l;
      logic [31:0] cmpv;
      logic [15:0] seen_aok, seen_dok;

      for (int i = 0; i < 2; i++) begin
         rstn[i] = 1'b0; rv[i] = 1'b0; ra[i] = 32'h0; rs[i] = 4'h0; rd[i] = 32'h0;
      end
      repeat (3) @(posedge clk);
      #1;
      rstn[0] = 1'b1;
      rstn[1] = 1'b1;

      // ---- LATENCY = 1 instance ----
      chk("lit.rst_led", led[0], 32'h0);
      chk("lit.rst_irq", irq[0], 32'h0);
      do_req(0, 32'h1FAF_0000, 4'hF, 32'hDEADBEEF, q, l);
      chk("lit.w_lat", l, 1);
      do_req(0, 32'h1FAF_0000, 4'h0, 32'h0, q, l);
      chk("lit.r_scratch0", q, 32'hDEADBEEF);
      chk("lit.r_lat", l, 1);

      do_req(0, 32'h1FAF_0004, 4'hF, 32'h11223344, q, l);
      do_req(0, 32'h1FAF_0004, 4'b0101, 32'hAABBCCDD, q, l);
      do_req(0, 32'h1FAF_0004, 4'h0, 32'h0, q, l);
      chk("lit.byte_merge", q, 32'h11BB33DD);

      do_req(0, 32'h1FAF_0008, 4'hF, 32'hFFFF1234, q, l);
      chk("lit.led_out", led[0], 32'h1234);
      do_req(0, 32'h1FAF_0008, 4'h0, 32'h0, q, l);
      chk("lit.led_read", q, 32'h0000_1234);

      do_req(0, 32'h1FB0_0000, 4'h0, 32'h0, q, l);
      chk("lit.outside_read", q, 32'h0);
      chk("lit.outside_lat", l, 1);
      do_req(0, 32'h1FB0_0000, 4'hF, 32'hFFFFFFFF, q, l);
      do_req(0, 32'h1FB0_0008, 4'hF, 32'hFFFFFFFF, q, l);
      do_req(0, 32'h1FAF_0018, 4'hF, 32'hFFFFFFFF, q, l);
      do_req(0, 32'h1FAF_0018, 4'h0, 32'h0, q, l);
      chk("lit.unmapped_read", q, 32'h0);
      do_req(0, 32'h1FAF_0003, 4'h0, 32'h0, q, l);
      chk("lit.keep_scratch0", q, 32'hDEADBEEF);
      do_req(0, 32'h1FAF_0004, 4'h0, 32'h0, q, l);
      chk("lit.keep_scratch1", q, 32'h11BB33DD);
      chk("lit.keep_led", led[0], 32'h1234);

`ifdef MMIO_TIMER_EN
      reset_pulse(0);
      do_req(0, 32'h1FAF_000C, 4'h0, 32'h0, q, l);     // accept in cycle 0
      chk("lit.counter0", q, 32'h0);
      do_req(0, 32'h1FAF_0010, 4'hF, 32'd20, q, l);    // accept in cycle 2
      repeat (16) @(negedge clk);                       // cycle 19
      chk("lit.irq_before", irq[0], 32'h0);
      @(negedge clk);                                   // cycle 20
      chk("lit.irq_at20", irq[0], 32'h1);
      @(posedge clk); #1;
      do_req(0, 32'h1FAF_0014, 4'h0, 32'h0, q, l);
      chk("lit.status_set", q, 32'h1);
      do_req(0, 32'h1FAF_0014, 4'h1, 32'h1, q, l);
      chk("lit.irq_cleared", irq[0], 32'h0);
      cmpv = m_cnt[0] + 32'd3;                          // counter+1 during the clear accept
      do_req(0, 32'h1FAF_0010, 4'hF, cmpv, q, l);
      do_req(0, 32'h1FAF_0014, 4'h1, 32'h1, q, l);
      chk("lit.set_wins", irq[0], 32'h1);
`else
      do_req(0, 32'h1FAF_0010, 4'hF, 32'd5, q, l);
      do_req(0, 32'h1FAF_0014, 4'hF, 32'hFFFFFFFF, q, l);
      do_req(0, 32'h1FAF_000C, 4'h0, 32'h0, q, l);
      chk("lit.no_counter", q, 32'h0);
      do_req(0, 32'h1FAF_0010, 4'h0, 32'h0, q, l);
      chk("lit.no_cmp", q, 32'h0);
      do_req(0, 32'h1FAF_0014, 4'h0, 32'h0, q, l);
      chk("lit.no_status", q, 32'h0);
      repeat (10) @(posedge clk);
      #1;
      chk("lit.no_irq", irq[0], 32'h0);
`endif

      // ---- LATENCY = 4 instance ----
      do_req(1, 32'h1FAF_0000, 4'hF, 32'hCAFEF00D, q, l);
      chk("lit.lat4", l, 4);
      rv[1] = 1'b1; ra[1] = 32'h1FAF_0000; rs[1] = 4'h0; rd[1] = 32'h0;
      seen_aok = 16'h0; seen_dok = 16'h0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clk);
         seen_aok[c] = aok[1];
         seen_dok[c] = dok[1];
         if (dok[1] === 1'b1) chk("lit.hold_data", dat[1], 32'hCAFEF00D);
         @(posedge clk); #1;
      end
      rv[1] = 1'b0;
      chk("lit.hold_aok", seen_aok, 16'h0421);
      chk("lit.hold_dok", seen_dok, 16'h4210);
      repeat (6) @(posedge clk);
      #1;

      rv[1] = 1'b1;
      seen_aok = 16'h0; seen_dok = 16'h0;
      for (int c = 0; c < 8; c++) begin
         if (c == 2) rstn[1] = 1'b0;
         if (c == 4) rstn[1] = 1'b1;
         @(negedge clk);
         seen_aok[c] = aok[1];
         seen_dok[c] = dok[1];
         @(posedge clk); #1;
      end
      rv[1] = 1'b0;
      chk("lit.rst_aok", seen_aok, 16'h0011);
      chk("lit.rst_dok", seen_dok, 16'h0000);
      repeat (4) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
